mem_protocol_checker: RTL
=========================

# mem_protocol_checker

Synthesizable, parametrised protocol and data-integrity checker for the single-port valid/ready memory interface (wr_rd, addr, wdata, rdata, valid, ready). It sits passively beside the memory and replaces pure immediate-style checking with sequential checks: handshake timeout, request stability, spurious ready, and read-data comparison against an internal shadow memory. Results go out as sticky error flags, saturating counters and a first-error capture, so both silicon debug and the testbench can read them.

## Interface
Parameters:
- ADDR_WIDTH, 4: address width; shadow depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8: wdata/rdata width.
- MAX_WAIT, 8: cycles valid may be held without ready before a timeout (1..255).
- CNT_WIDTH, 16: width of the transfer and error counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- res  in  1  reset, synchronous, active-low.
- clr  in  1  synchronous clear of flags, counters and capture. The shadow memory is kept.
- wr_rd  in  1  1 = write, 0 = read.
- addr  in  ADDR_WIDTH  request address.
- wdata  in  DATA_WIDTH  write data.
- rdata  in  DATA_WIDTH  read data, valid in the handshake cycle of a read.
- valid  in  1  request valid.
- ready  in  1  memory ready.
- err_flags  out  4  sticky: [0] timeout, [1] stability, [2] ready-without-valid, [3] data mismatch.
- err_count  out  CNT_WIDTH  total error events, saturating.
- wr_count  out  CNT_WIDTH  completed writes, saturating.
- rd_count  out  CNT_WIDTH  completed reads, saturating.
- first_err_addr  out  ADDR_WIDTH  addr of the first error since reset/clr.
- first_err_code  out  4  one-hot code of that first error.

## Operation
- A transfer is a cycle with valid=1 and ready=1.
- FSM states:
  - IDLE→WAIT: valid=1 and ready=0. Latch wr_rd/addr/wdata and load wait_cnt=1.
  - IDLE→IDLE: on a transfer or with valid=0.
  - WAIT→IDLE: on a transfer.
  - WAIT→WAIT: otherwise, with wait_cnt incremented and saturating at MAX_WAIT.
  - WAIT→IDLE with no transfer: valid drops before ready. This is also a stability error.
- Timeout: in WAIT, when wait_cnt reaches MAX_WAIT and ready=0, raise flag[0] once per stalled request. No repeat until the FSM returns to IDLE.
- Stability: in WAIT, any change of wr_rd, addr or wdata (wdata only when the latched wr_rd=1), or valid falling, raises flag[1].
- Ready-without-valid: ready=1 while valid=0 raises flag[2].
- Write transfer: shadow[addr]←wdata, written[addr]←1, wr_count+1.
- Read transfer: rd_count+1. If written[addr]=1 and rdata≠shadow[addr], raise flag[3]. Unwritten locations are not compared.
- Each cycle, err_count advances by 1 if any error is detected in that cycle. Several errors in one cycle count once but set every matching flag.
- First-error capture loads only while err_flags==0. first_err_code may be multi-hot if the first errors are simultaneous.
- clr=1 zeroes err_flags, err_count, wr_count, rd_count, first_err_addr and first_err_code, and returns the FSM to IDLE. Events in a clr cycle are discarded.
- res=0 clears everything clr clears, plus all written[] bits. Shadow data contents are don't-care.

## Timing
- Reset value of every output is 0, one cycle after res is sampled low.
- All outputs are registered. Flags, counters and capture reflect an event at edge N after edge N, visible in cycle N+1.
- Timeout fires on the edge where valid has been high without ready for MAX_WAIT consecutive edges.
- Write then read of the same addr in back-to-back cycles compares against the new data. A write is visible to a read on the next transfer.
- Counters saturate at 2**CNT_WIDTH-1 and do not wrap.
- Reset asserted mid-WAIT: FSM goes to IDLE with no flag raised for the abandoned request.

## Test plan
- Reset: drive res=0 for 2 cycles with random inputs → all outputs 0, FSM IDLE.
- Clean traffic: write 0xA5 to addr 3, then read addr 3 with rdata=0xA5, all ready on first cycle → wr_count=1, rd_count=1, err_flags=0.
- Mismatch: write 0x3C to addr 7, then read addr 7 with rdata=0x3D → err_flags=4'b1000, first_err_addr=7, err_count=1. Reading unwritten addr 9 with any rdata adds no error.
- Timeout: valid=1, ready=0 for 10 cycles with MAX_WAIT=8 → flag[0] set exactly once, err_count=1. Then ready=1 → wr_count or rd_count +1.
- Stability and spurious ready: change addr from 2 to 5 during a stall, and separately pulse ready with valid=0 → err_flags=4'b0110, err_count=2, first_err_code=4'b0010.
- clr and saturation: with CNT_WIDTH=4, issue 20 writes → wr_count=15. Pulse clr → counters and flags 0. A read of a previously written addr is still compared.

Source files
------------

// File: rtl/mem_protocol_checker.sv
// Passive checker for a single-port valid/ready memory interface.
// Flags handshake timeouts, unstable requests, spurious ready and read-data mismatches.
module mem_protocol_checker #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  clr,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  valid,
  input  logic                  ready,
  output logic [3:0]            err_flags,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [3:0]            first_err_code
);

  // state | meaning
  // IDLE  | no request outstanding
  // WAIT  | request presented, ready not yet seen
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam int          DEPTH = 1 << ADDR_WIDTH;
  localparam logic [7:0]  MAX_W = 8'(MAX_WAIT);

  logic [0:0]            state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d, cnt_next;
  logic                  lat_wr_q;
  logic [ADDR_WIDTH-1:0] lat_addr_q;
  logic [DATA_WIDTH-1:0] lat_wdata_q;
  logic [DATA_WIDTH-1:0] shadow_q [DEPTH];
  logic [DEPTH-1:0]      written_q;
  logic [3:0]            flags_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q, wr_cnt_q, rd_cnt_q;
  logic [ADDR_WIDTH-1:0] first_addr_q;
  logic [3:0]            first_code_q;

  logic       xfer, stall;
  logic [3:0] err_vec;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    xfer     = valid & ready;
    stall    = valid & ~ready;
    cnt_next = 8'd1;
    if (state_q == WAIT)
      cnt_next = (wait_cnt_q >= MAX_W) ? MAX_W : wait_cnt_q + 8'd1;

    err_vec    = 4'b0000;
    // A timeout fires only on the edge the count first reaches the limit.
    err_vec[0] = stall & (cnt_next == MAX_W) & ~((state_q == WAIT) & (wait_cnt_q == MAX_W));
    err_vec[1] = (state_q == WAIT) &
                 (~valid | (wr_rd != lat_wr_q) | (addr != lat_addr_q) |
                  (lat_wr_q & (wdata != lat_wdata_q)));
    err_vec[2] = ready & ~valid;
    err_vec[3] = xfer & ~wr_rd & written_q[addr] & (rdata != shadow_q[addr]);

    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: if (stall) begin
        state_d    = WAIT;
        wait_cnt_d = 8'd1;
      end
      WAIT: if (xfer || !valid) begin
        state_d    = IDLE;
        wait_cnt_d = 8'd0;
      end else begin
        wait_cnt_d = cnt_next;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 8'd0;
      written_q    <= '0;
      flags_q      <= 4'b0000;
      err_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      first_addr_q <= '0;
      first_code_q <= 4'b0000;
    end else if (clr) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 8'd0;
      flags_q      <= 4'b0000;
      err_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      first_addr_q <= '0;
      first_code_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      flags_q    <= flags_q | err_vec;
      if (|err_vec) err_cnt_q <= sat_inc(err_cnt_q);
      if (xfer && wr_rd) begin
        wr_cnt_q        <= sat_inc(wr_cnt_q);
        written_q[addr] <= 1'b1;
      end
      if (xfer && !wr_rd) rd_cnt_q <= sat_inc(rd_cnt_q);
      if ((flags_q == 4'b0000) && (|err_vec)) begin
        first_addr_q <= addr;
        first_code_q <= err_vec;
      end
    end
  end

  // Request fields are re-latched every valid cycle so stability compares cycle to cycle.
  always_ff @(posedge clk) begin
    if (valid) begin
      lat_wr_q    <= wr_rd;
      lat_addr_q  <= addr;
      lat_wdata_q <= wdata;
    end
    if (res && !clr && xfer && wr_rd) shadow_q[addr] <= wdata;
  end

  assign err_flags      = flags_q;
  assign err_count      = err_cnt_q;
  assign wr_count       = wr_cnt_q;
  assign rd_count       = rd_cnt_q;
  assign first_err_addr = first_addr_q;
  assign first_err_code = first_code_q;

endmodule
